// File: rtl/des_subkey_generator.sv
// -----------------------------------------------------------------------------
// des_subkey_generator
//
// Purpose:
//   Key-schedule engine for a DES round datapath. After a key load it emits the
//   sixteen 48-bit round subkeys one at a time. Encrypt mode emits K1..K16.
//   Decrypt mode emits K16..K1 by rotating the C/D halves to the right, so the
//   same round datapath performs decryption.
//
//   The C and D halves are kept in registers. The subkey is PC-2 of {C,D},
//   computed combinationally from those registers. Advancing one round rotates
//   C and D by the shift count of the FIPS 46-3 schedule.
//
// Ports:
//   clk           in   1   system clock, rising edge
//   n_rst         in   1   asynchronous reset, active-low
//   key_load      in   1   one-cycle pulse: capture key_in/decrypt, restart
//   key_in        in  64   DES key, key_in[63] = DES bit 1 (parity ignored)
//   decrypt       in   1   mode, sampled only on key_load (1 = reverse order)
//   next_key      in   1   advance to the next subkey (only while valid)
//   subkey        out 48   current subkey, subkey[47] = DES bit 1
//   round_idx     out  4   schedule position 0..15
//   subkey_valid  out  1   subkey is valid for round round_idx
//   schedule_done out  1   all 16 subkeys consumed
// -----------------------------------------------------------------------------
module des_subkey_generator (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        key_load,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        next_key,
    output logic [47:0] subkey,
    output logic [3:0]  round_idx,
    output logic        subkey_valid,
    output logic        schedule_done
);

    // -------------------------------------------------------------------------
    // Permuted Choice 1: output bit i (1-based, MSB first) takes DES key bit
    // PC1[i]. Entries are packed 6 bits each, entry 1 in the top slot.
    // -------------------------------------------------------------------------
    localparam logic [56*6-1:0] PC1_TAB = {
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    // -------------------------------------------------------------------------
    // Permuted Choice 2: subkey bit j (1-based, MSB first) takes bit PC2[j]
    // of the 56-bit {C,D} vector (bit 1 = C MSB).
    // -------------------------------------------------------------------------
    localparam logic [48*6-1:0] PC2_TAB = {
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // -------------------------------------------------------------------------
    // Schedule state. One-hot encoding lets the status outputs come straight
    // from a single state flop, so they cannot glitch during a state change.
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_ACTIVE = 3'b010,
        ST_DONE   = 3'b100
    } state_e;

    localparam int ACTIVE_BIT = 1;
    localparam int DONE_BIT   = 2;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // DES bit n of the key lives at key_in[64-n]. Parity bits (DES bits
    // 8,16,...,64) are never selected by PC-1.
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] cd;
        logic [5:0]  src;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            src        = PC1_TAB[(55 - i) * 6 +: 6];
            cd[55 - i] = key[64 - int'(src)];
        end
        return cd;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] k;
        logic [5:0]  src;
        k = '0;
        for (int j = 0; j < 48; j++) begin
            src       = PC2_TAB[(47 - j) * 6 +: 6];
            k[47 - j] = cd[56 - int'(src)];
        end
        return k;
    endfunction

    // Shift table S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
    // Returns 1'b1 for a single-bit shift, 1'b0 for a double shift.
    function automatic logic is_single_shift(input logic [4:0] n);
        return (n == 5'd1) || (n == 5'd2) || (n == 5'd9) || (n == 5'd16);
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic single);
        return single ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic single);
        return single ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    // -------------------------------------------------------------------------
    // Registers and internal wires
    // -------------------------------------------------------------------------
    state_e      r_state;
    state_e      w_state_next;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic        r_mode;
    logic [3:0]  r_round_idx;

    logic [55:0] w_pc1;
    logic        w_enc_single;
    logic        w_dec_single;
    logic        w_advance;
    logic        w_last_round;

    // -------------------------------------------------------------------------
    // Combinational helpers for the datapath.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a value on every path first, so
        // no latch can be inferred whatever the branch structure becomes.
        w_pc1        = pc1(key_in);
        // Encrypt: moving from position p to p+1 produces K(p+2), so the
        // rotation is S[p+2].
        w_enc_single = is_single_shift({1'b0, r_round_idx} + 5'd2);
        // Decrypt: position p holds K(16-p); undoing its shift S[16-p] yields
        // the previous key in the forward schedule.
        w_dec_single = is_single_shift(5'd16 - {1'b0, r_round_idx});
        w_last_round = (r_round_idx == 4'd15);
        // key_load has priority, so a simultaneous next_key is discarded.
        w_advance    = r_state[ACTIVE_BIT] && next_key && !key_load;
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: sequential state is updated only with non-blocking assignments
        // so every flop samples values from before the clock edge.
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (key_load) begin
            w_state_next = ST_ACTIVE;
        end else begin
            unique case (r_state)
                ST_IDLE:   w_state_next = ST_IDLE;
                ST_ACTIVE: w_state_next = (next_key && w_last_round) ? ST_DONE : ST_ACTIVE;
                ST_DONE:   w_state_next = ST_DONE;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs. Status flags are single state flops; the subkey is a pure
    // permutation of the C/D registers.
    // -------------------------------------------------------------------------
    always_comb begin
        subkey        = pc2({r_c, r_d});
        round_idx     = r_round_idx;
        subkey_valid  = r_state[ACTIVE_BIT];
        schedule_done = r_state[DONE_BIT];
    end

    // -------------------------------------------------------------------------
    // Key-schedule datapath: C, D, mode and round position.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: every datapath register is reset, so subkey reads as zero
        // straight out of reset rather than as unknown.
        if (!n_rst) begin
            r_c         <= '0;
            r_d         <= '0;
            r_mode      <= 1'b0;
            r_round_idx <= '0;
        end else if (key_load) begin
            r_mode      <= decrypt;
            r_round_idx <= '0;
            if (decrypt) begin
                // C16/D16 equal C0/D0 (total rotation is 28), so K16 is
                // PC-2 of the unrotated PC-1 output.
                r_c <= w_pc1[55:28];
                r_d <= w_pc1[27:0];
            end else begin
                // K1 uses a single left shift (S[1] = 1).
                r_c <= rotl28(w_pc1[55:28], 1'b1);
                r_d <= rotl28(w_pc1[27:0],  1'b1);
            end
        end else if (w_advance && !w_last_round) begin
            r_round_idx <= r_round_idx + 4'd1;
            if (r_mode) begin
                r_c <= rotr28(r_c, w_dec_single);
                r_d <= rotr28(r_d, w_dec_single);
            end else begin
                r_c <= rotl28(r_c, w_enc_single);
                r_d <= rotl28(r_d, w_enc_single);
            end
        end
    end

endmodule

// File: tb/tb_des_subkey_generator.sv
// -----------------------------------------------------------------------------
// tb_des_subkey_generator
//
// Self-checking bench for des_subkey_generator. A reference model builds the
// full 16-entry schedule directly from the FIPS 46-3 tables: each subkey is
// PC-2 applied to C0/D0 rotated left by the cumulative shift count. Decrypt
// expectations are that list read backwards.
// -----------------------------------------------------------------------------
module tb_des_subkey_generator;

    localparam logic [63:0] TEST_KEY = 64'h133457799BBCDFF1;
    localparam logic [47:0] K1_VEC   = 48'h1B02EFFC7072;
    localparam logic [47:0] K2_VEC   = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16_VEC  = 48'hCB3D8B0E17F5;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk;
    logic        n_rst;
    logic        key_load;
    logic [63:0] key_in;
    logic        decrypt;
    logic        next_key;
    logic [47:0] subkey;
    logic [3:0]  round_idx;
    logic        subkey_valid;
    logic        schedule_done;

    int          n_checks;
    int          n_fail;
    logic [47:0] ref_ks [16];   // ref_ks[r] = K(r+1)

    des_subkey_generator dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .key_load      (key_load),
        .key_in        (key_in),
        .decrypt       (decrypt),
        .next_key      (next_key),
        .subkey        (subkey),
        .round_idx     (round_idx),
        .subkey_valid  (subkey_valid),
        .schedule_done (schedule_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [47:0] exp_sk,
                             input int exp_idx, input logic exp_v, input logic exp_d);
        check({tag, ".subkey"}, 64'(subkey), 64'(exp_sk));
        check({tag, ".round_idx"}, 64'(round_idx), 64'(exp_idx));
        check({tag, ".valid"}, 64'(subkey_valid), 64'(exp_v));
        check({tag, ".done"}, 64'(schedule_done), 64'(exp_d));
    endtask

    // Reference schedule: K(r) = PC2(C0 <<< T(r), D0 <<< T(r)) with
    // T(r) = S[1] + ... + S[r].
    task automatic build_ref(input logic [63:0] key);
        bit c0 [28];
        bit d0 [28];
        int tot;
        int p;
        logic [47:0] k;
        for (int i = 0; i < 28; i++) begin
            c0[i] = key[64 - PC1_T[i]];
            d0[i] = key[64 - PC1_T[28 + i]];
        end
        tot = 0;
        for (int r = 0; r < 16; r++) begin
            tot += SHIFTS[r];
            for (int j = 0; j < 48; j++) begin
                p = PC2_T[j];
                if (p <= 28) k[47 - j] = c0[(p - 1 + tot) % 28];
                else         k[47 - j] = d0[(p - 29 + tot) % 28];
            end
            ref_ks[r] = k;
        end
    endtask

    function automatic logic [47:0] expected_key(input bit dec, input int pos);
        return dec ? ref_ks[15 - pos] : ref_ks[pos];
    endfunction

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [63:0] key, input logic dec);
        key_load = 1'b1;
        key_in   = key;
        decrypt  = dec;
        tick();
        key_load = 1'b0;
        decrypt  = ~dec;   // must have no effect outside key_load
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_rst    = 1'b0;
        key_load = 1'b0;
        key_in   = '0;
        decrypt  = 1'b0;
        next_key = 1'b0;

        // ---------------- Reset then idle ----------------
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 48'h0, 0, 1'b0, 1'b0);
        n_rst = 1'b1;
        tick();
        next_key = 1'b1;
        repeat (3) tick();
        next_key = 1'b0;
        check_out("idle_next", 48'h0, 0, 1'b0, 1'b0);

        // ---------------- Encrypt schedule ----------------
        build_ref(TEST_KEY);
        do_load(TEST_KEY, 1'b0);
        check("enc_k1_vec", 64'(subkey), 64'(K1_VEC));
        check_out("enc_r0", expected_key(1'b0, 0), 0, 1'b1, 1'b0);
        next_key = 1'b1;
        for (int r = 1; r < 16; r++) begin
            tick();
            if (r == 1) check("enc_k2_vec", 64'(subkey), 64'(K2_VEC));
            if (r == 15) check("enc_k16_vec", 64'(subkey), 64'(K16_VEC));
            check_out($sformatf("enc_r%0d", r), expected_key(1'b0, r), r, 1'b1, 1'b0);
        end
        tick();
        next_key = 1'b0;
        check_out("enc_done", K16_VEC, 15, 1'b0, 1'b1);
        next_key = 1'b1;
        repeat (2) tick();
        next_key = 1'b0;
        check_out("enc_done_hold", K16_VEC, 15, 1'b0, 1'b1);

        // ---------------- Decrypt schedule ----------------
        do_load(TEST_KEY, 1'b1);
        check("dec_first_vec", 64'(subkey), 64'(K16_VEC));
        check_out("dec_r0", expected_key(1'b1, 0), 0, 1'b1, 1'b0);
        next_key = 1'b1;
        for (int r = 1; r < 16; r++) begin
            tick();
            if (r == 14) check("dec_r14_vec", 64'(subkey), 64'(K2_VEC));
            if (r == 15) check("dec_r15_vec", 64'(subkey), 64'(K1_VEC));
            check_out($sformatf("dec_r%0d", r), expected_key(1'b1, r), r, 1'b1, 1'b0);
        end
        tick();
        next_key = 1'b0;
        check_out("dec_done", K1_VEC, 15, 1'b0, 1'b1);

        // ---------------- Stall and hold, random keys/modes ----------------
        for (int t = 0; t < 6; t++) begin
            logic [63:0] key;
            bit          dec;
            int          pos;
            bit          done;
            bit          nk;
            key  = (t == 0) ? TEST_KEY : {$urandom, $urandom};
            dec  = (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            build_ref(key);
            do_load(key, dec);
            pos  = 0;
            done = 0;
            check_out($sformatf("rnd%0d_load", t), expected_key(dec, 0), 0, 1'b1, 1'b0);
            for (int cyc = 0; cyc < 80 && !done; cyc++) begin
                nk       = ($urandom_range(0, 2) == 0);
                next_key = nk;
                decrypt  = 1'($urandom_range(0, 1));
                tick();
                if (nk) begin
                    if (pos < 15) pos++;
                    else          done = 1;
                end
                check_out($sformatf("rnd%0d_c%0d", t, cyc), expected_key(dec, pos),
                          pos, !done, done);
            end
            next_key = 1'b0;
            check($sformatf("rnd%0d_finished", t), 64'(done), 64'(1));
        end

        // ---------------- Restart priority ----------------
        build_ref(TEST_KEY);
        do_load(TEST_KEY, 1'b0);
        next_key = 1'b1;
        repeat (7) tick();
        check_out("restart_pre", expected_key(1'b0, 7), 7, 1'b1, 1'b0);
        key_load = 1'b1;
        key_in   = TEST_KEY;
        decrypt  = 1'b1;
        tick();
        key_load = 1'b0;
        next_key = 1'b0;
        check_out("restart", K16_VEC, 0, 1'b1, 1'b0);

        // ---------------- Async reset mid-run ----------------
        do_load(TEST_KEY, 1'b0);
        next_key = 1'b1;
        repeat (5) tick();
        next_key = 1'b0;
        check_out("arst_pre", expected_key(1'b0, 5), 5, 1'b1, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        check_out("arst_now", 48'h0, 0, 1'b0, 1'b0);
        #2;
        n_rst = 1'b1;
        next_key = 1'b1;
        repeat (3) tick();
        next_key = 1'b0;
        check_out("arst_ignore", 48'h0, 0, 1'b0, 1'b0);
        do_load(TEST_KEY, 1'b0);
        check_out("arst_reload", K1_VEC, 0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
